// File: rtl/scan_enc_pkg.sv
// Shared types, widths, GF(2^8) helpers and FIPS-197 vectors for the
// scan TDO encryptor. No ports.
package scan_enc_pkg;

  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 128;
  localparam int CNT_W   = 7;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    ENCRYPT,
    SHIFT_OUT
  } state_t;

  localparam logic [127:0] FIPS_KEY =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam logic [127:0] FIPS_B_KEY =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_B_PT =
    128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_B_CT =
    128'h3925841d02dc09fbdc118597196a0b32;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // S-box computed as x^254 (the field inverse, 0 -> 0)
  // followed by the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] v;
    t = x;
    v = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      v = gmul(v, t);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/scan_encrypt_tdo_if.sv
// Handshake/data bundle between the scan TDO path and the encryptor.
// master: drives start/en/serial_in/initial_key; slave: drives the rest.
interface scan_encrypt_tdo_if;
  import scan_enc_pkg::*;

  logic             start;
  logic             en;
  logic             serial_in;
  logic [KEY_W-1:0] initial_key;
  logic             serial_out;
  logic             in_ready;
  logic             out_valid;
  logic             busy;
  logic             overrun;

  modport master (
    output start, en, serial_in, initial_key,
    input  serial_out, in_ready, out_valid, busy, overrun
  );

  modport slave (
    input  start, en, serial_in, initial_key,
    output serial_out, in_ready, out_valid, busy, overrun
  );

endinterface

// File: rtl/aes128_enc_core.sv
// Iterative AES-128 encryptor, one round per tck after a start pulse.
// Ports: tck, reset_n, start, key, plaintext -> ciphertext, done pulse.
module aes128_enc_core
  import scan_enc_pkg::*;
(
  input  logic         tck,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic [127:0] ciphertext,
  output logic         done
);

  logic [127:0] r_st;
  logic [127:0] r_rk;
  logic [7:0]   r_rcon;
  logic [3:0]   r_rnd;
  logic         r_run;
  logic         r_done;
  logic [127:0] w_sr;
  logic [127:0] w_nk;

  // Byte i of the state lives at [127-8i -: 8], column-major.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] =
          sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_next(
    input logic [127:0] rk,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3, t;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]),
          sbox(w3[7:0]),   sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign w_sr = sub_shift(r_st);
  assign w_nk = key_next(r_rk, r_rcon);

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      r_st   <= '0;
      r_rk   <= '0;
      r_rcon <= '0;
      r_rnd  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_st   <= plaintext ^ key;
        r_rk   <= key;
        r_rcon <= 8'h01;
        r_rnd  <= 4'd1;
        r_run  <= 1'b1;
      end else if (r_run) begin
        r_rk   <= w_nk;
        r_rcon <= xt(r_rcon);
        r_rnd  <= r_rnd + 4'd1;
        if (r_rnd == 4'd10) begin
          r_st   <= w_sr ^ w_nk;
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_st <= mix(w_sr) ^ w_nk;
        end
      end
    end
  end

  assign ciphertext = r_st;
  assign done       = r_done;

endmodule

// File: rtl/scan_encrypt_tdo.sv
// Serial TDO encryptor: SIPO 128 bits, AES-128, PISO out. CBC when
// SCAN_ENC_CBC_EN is defined. Ports: tck, reset_n, bus (slave modport).
module scan_encrypt_tdo
  import scan_enc_pkg::*;
(
  input logic               tck,
  input logic               reset_n,
  scan_encrypt_tdo_if.slave bus
);

  state_t             r_state;
  logic [BLOCK_W-1:0] r_sipo;
  logic [BLOCK_W-1:0] r_piso;
  logic [KEY_W-1:0]   r_key;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_core_start;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_overrun;
  logic [BLOCK_W-1:0] w_pt;
  logic [BLOCK_W-1:0] w_ct;
  logic               w_done;

`ifdef SCAN_ENC_CBC_EN
  logic [BLOCK_W-1:0] r_chain;

  assign w_pt = r_sipo ^ r_chain;

  // IV is zero at the start of every session.
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n)
      r_chain <= '0;
    else if (r_state == IDLE && bus.start)
      r_chain <= '0;
    else if (w_done)
      r_chain <= w_ct;
  end
`else
  assign w_pt = r_sipo;
`endif

  aes128_enc_core u_core (
    .tck        (tck),
    .reset_n    (reset_n),
    .start      (r_core_start),
    .key        (r_key),
    .plaintext  (w_pt),
    .ciphertext (w_ct),
    .done       (w_done)
  );

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_sipo       <= '0;
      r_piso       <= '0;
      r_key        <= '0;
      r_cnt        <= '0;
      r_core_start <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      if (bus.en && !r_in_ready && !r_out_valid)
        r_overrun <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state    <= COLLECT;
            r_key      <= bus.initial_key;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        COLLECT: begin
          if (bus.en) begin
            r_sipo <= {r_sipo[BLOCK_W-2:0], bus.serial_in};
            r_cnt  <= r_cnt + 1'b1;
            if (&r_cnt) begin
              r_state      <= ENCRYPT;
              r_in_ready   <= 1'b0;
              r_core_start <= 1'b1;
            end
          end
        end
        ENCRYPT: begin
          if (w_done) begin
            r_piso      <= w_ct;
            r_cnt       <= '0;
            r_state     <= SHIFT_OUT;
            r_out_valid <= 1'b1;
          end
        end
        SHIFT_OUT: begin
          if (bus.en) begin
            r_piso <= {r_piso[BLOCK_W-2:0], 1'b0};
            r_cnt  <= r_cnt + 1'b1;
            if (&r_cnt) begin
              r_out_valid <= 1'b0;
              r_cnt       <= '0;
              if (bus.start) begin
                r_state    <= COLLECT;
                r_in_ready <= 1'b1;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.serial_out = r_out_valid & r_piso[BLOCK_W-1];
  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.busy       = r_busy;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_scan_encrypt_tdo.sv
// Scoreboard bench for scan_encrypt_tdo using FIPS-197 vectors.
// Drives and samples on the falling edge of tck.
module tb_scan_encrypt_tdo;
  import scan_enc_pkg::*;

  logic tck = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_pass = 0;
  logic q_exp[$];
  logic exp_ovr;

  scan_encrypt_tdo_if bus();

  scan_encrypt_tdo u_dut (
    .tck     (tck),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 tck = ~tck;

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // One cycle: check any bit consumed at the coming edge, drive, advance.
  task automatic cyc(input logic e, input logic b, output logic acc);
    logic x;
    acc = e & bus.in_ready;
    if (e && !bus.in_ready && !bus.out_valid) exp_ovr = 1'b1;
    if (e && bus.out_valid) begin
      chk("sb_depth", 128'(q_exp.size() != 0), 128'd1);
      x = (q_exp.size() != 0) ? q_exp.pop_front() : 1'b0;
      chk("tdo", 128'(bus.serial_out), 128'(x));
    end
    bus.en = e;
    bus.serial_in = b;
    @(negedge tck);
  endtask

  task automatic start_sess(input logic [127:0] key);
    bus.initial_key = key;
    bus.start = 1'b1;
    bus.en = 1'b0;
    @(negedge tck);
    chk("sess", 128'({bus.busy, bus.in_ready, bus.out_valid}), 128'd6);
  endtask

  task automatic send_block(
    input logic [127:0] pt,
    input logic [127:0] ct,
    input bit           gap,
    input int           drop
  );
    int   got = 0;
    int   budget = 2000;
    logic acc;
    logic e;
    chk("in_ready", 128'(bus.in_ready), 128'd1);
    while (got < 128 && budget > 0) begin
      e = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(e, pt[127-got], acc);
      if (acc) got++;
      if (got == drop) bus.start = 1'b0;
      budget--;
    end
    chk("send_done", 128'(got), 128'd128);
    for (int i = 127; i >= 0; i--) q_exp.push_back(ct[i]);
  endtask

  task automatic wait_out(input logic e);
    int n = 0;
    while (!bus.out_valid && n < 64) begin
      chk("rdy_enc", 128'(bus.in_ready), 128'd0);
      if (e && !bus.in_ready) exp_ovr = 1'b1;
      bus.en = e;
      @(negedge tck);
      n++;
    end
    chk("out_valid", 128'(bus.out_valid), 128'd1);
    chk("ovr_enc", 128'(bus.overrun), 128'(exp_ovr));
  endtask

  task automatic recv_block(input bit gap, input int nbits);
    int   got = 0;
    int   budget = 2000;
    logic e;
    logic c;
    logic acc;
    while (got < nbits && budget > 0) begin
      e = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      c = e & bus.out_valid;
      if (c && got == 127) chk("busy_last", 128'(bus.busy), 128'd1);
      cyc(e, 1'($urandom_range(0, 1)), acc);
      if (c) got++;
      budget--;
    end
    chk("recv_done", 128'(got), 128'(nbits));
  endtask

  task automatic post_idle();
    chk("idle", 128'({bus.busy, bus.out_valid, bus.in_ready,
                      bus.serial_out}), 128'd0);
    chk("ovr", 128'(bus.overrun), 128'(exp_ovr));
    chk("sb_empty", 128'(q_exp.size()), 128'd0);
    bus.en = 1'b0;
    bus.serial_in = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.en = 1'b0;
    bus.serial_in = 1'b0;
    bus.initial_key = '0;
    exp_ovr = 1'b0;
    repeat (2) @(negedge tck);
    chk("rst", 128'({bus.serial_out, bus.in_ready, bus.out_valid,
                     bus.busy, bus.overrun}), 128'd0);
    reset_n = 1'b1;
    @(negedge tck);
    chk("idle0", 128'({bus.busy, bus.in_ready}), 128'd0);

    // Continuous strobes
    start_sess(FIPS_KEY);
    send_block(FIPS_PT, FIPS_CT, 1'b0, 1);
    wait_out(1'b0);
    recv_block(1'b0, 128);
    post_idle();

    // Gapped strobes
    start_sess(FIPS_KEY);
    send_block(FIPS_PT, FIPS_CT, 1'b1, 1);
    wait_out(1'b0);
    recv_block(1'b1, 128);
    post_idle();

    // Back-to-back, start held
    start_sess(FIPS_KEY);
    send_block(FIPS_PT, FIPS_CT, 1'b0, -1);
    wait_out(1'b0);
    recv_block(1'b0, 128);
    chk("b2b", 128'({bus.busy, bus.in_ready, bus.out_valid}), 128'd6);
    send_block(FIPS_PT, FIPS_CT, 1'b0, -1);
    wait_out(1'b0);
    bus.start = 1'b0;
    recv_block(1'b0, 128);
    post_idle();

    // Start dropped at bit 60
    start_sess(FIPS_KEY);
    send_block(FIPS_PT, FIPS_CT, 1'b0, 60);
    wait_out(1'b0);
    recv_block(1'b0, 128);
    post_idle();

    // en held through ENCRYPT
    start_sess(FIPS_KEY);
    send_block(FIPS_PT, FIPS_CT, 1'b0, 1);
    wait_out(1'b1);
    chk("ovr_set", 128'(bus.overrun), 128'd1);
    recv_block(1'b0, 128);
    post_idle();
    repeat (3) @(negedge tck);
    chk("ovr_sticky", 128'(bus.overrun), 128'(exp_ovr));

    // Reset mid SHIFT_OUT, then a fresh block
    start_sess(FIPS_B_KEY);
    send_block(FIPS_B_PT, FIPS_B_CT, 1'b0, 1);
    wait_out(1'b0);
    recv_block(1'b0, 40);
    chk("pre_arst", 128'({bus.busy, bus.out_valid}), 128'd3);
    reset_n = 1'b0;
    #1;
    chk("arst", 128'({bus.serial_out, bus.in_ready, bus.out_valid,
                      bus.busy, bus.overrun}), 128'd0);
    q_exp.delete();
    exp_ovr = 1'b0;
    bus.en = 1'b0;
    @(negedge tck);
    reset_n = 1'b1;
    @(negedge tck);
    start_sess(FIPS_B_KEY);
    send_block(FIPS_B_PT, FIPS_B_CT, 1'b0, 1);
    wait_out(1'b0);
    recv_block(1'b0, 128);
    post_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
